secret_file_loader: RTL and testbench
=====================================

Name: secret_file_loader

Overview:
- Host-side driver for the 7-bit word/play interface of the secret-file glyph display block.
- Buffers up to WORD_COUNT 7-bit message words from a valid/ready write port, shifts them out on the display's 7-bit data input (oldest first, zero-padded to exactly WORD_COUNT words), then drives the play code 7'h7F for a programmed number of cycles.
- Sits between the host logic and the display's `din` pins; its registered `din_out` connects directly to those pins.

Parameters:
- WORD_COUNT, 16: message depth; must equal the display's buffer depth.
- PLAY_W, 16: width of the play-length counter.

Ports:
- clk  input  1  clock; same clock as the display block.
- rst  input  1  asynchronous, active-high reset.
- wr_valid  input  1  host presents a message word.
- wr_ready  output  1  word accepted when wr_valid && wr_ready.
- wr_data  input  7  word: bit6=1 selects glyph code [5:0]; bit6=0 selects raw column {0,[5:0],0}.
- clear  input  1  empties the message buffer (IDLE only).
- start  input  1  begins a load+play sequence (IDLE only).
- stop  input  1  ends PLAY early.
- play_len  input  PLAY_W  play cycles; latched at start; 0 = play until stop.
- din_out  output  7  registered drive to the display data input.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse on return to IDLE from PLAY.
- sanitized  output  1  one-cycle pulse when an accepted word was 7'h7F.
- count  output  $clog2(WORD_COUNT+1)  words currently buffered.

Behaviour:
- Reset (async, any state):
  - state=IDLE, count=0, din_out=7'h00, done=0, sanitized=0, counters=0.
  - Buffer contents are don't-care.
- States: IDLE, LOAD, PLAY.
- IDLE:
  - din_out=7'h00.
  - wr_ready = (count < WORD_COUNT); it is 0 in LOAD and PLAY.
  - An accepted word is written at index count, and count increments.
  - 7'h7F must never reach the display as data. An accepted 7'h7F is stored as 7'h00 and sanitized pulses on the next cycle.
  - clear: count<=0. Clear has priority over a same-cycle write and over start.
  - start with count==0: ignored.
  - start with count>0: latch play_len, idx<=0, go to LOAD. A write in the same cycle as start is not accepted, because wr_ready is low there.
- LOAD:
  - Exactly WORD_COUNT cycles.
  - Cycle i drives din_out = buf[i] if i<count, else 7'h00 (pad).
  - On i==WORD_COUNT-1, go to PLAY with the play counter at 0.
  - Ordering: the display shifts new words in at the top, so word 0 ends at the bottom and is played first.
  - stop is ignored in LOAD.
- PLAY:
  - din_out=7'h7F.
  - Exits to IDLE when stop is high, or when the counter reaches play_len-1 with play_len!=0. stop wins if both occur in the same cycle.
  - With play_len=0, PLAY holds until stop.
  - Counter is PLAY_W bits. It must not wrap-exit: with play_len=0 it saturates or freely wraps without ending PLAY.
- Exit from PLAY:
  - done=1 in the first IDLE cycle, in which din_out=7'h00.
  - Buffer and count are retained; a new start replays the same message.
- Timing (start sampled at edge k):
  - din_out = word0 during cycle k+1.
  - word i during cycle k+1+i.
  - 7'h7F from cycle k+1+WORD_COUNT, for play_len cycles.
  - done in cycle k+1+WORD_COUNT+play_len.
- busy is combinational from the state register. din_out, done and sanitized are registered.
- Reset mid-LOAD or mid-PLAY: din_out drops to 7'h00 asynchronously and count=0. No done pulse.

Test Plan:
- Reset, then write 7'h41, 7'h42, 7'h03; start with play_len=20 -> din_out sequence 41, 42, 03, then thirteen 00, then twenty 7F, then 00 with done=1 in that cycle; busy high for exactly 36 cycles.
- Write 16 words -> wr_ready=0 and count=16; a 17th wr_valid is not accepted; start -> all 16 words are driven, with no padding.
- Write 7'h7F -> stored and driven as 7'h00; sanitized pulses once; count increments.
- start with play_len=0; hold 100 cycles, then pulse stop -> din_out=7F for the whole hold; on the cycle after stop, din_out=00 and done=1; a second start replays the identical load sequence.
- clear and start asserted in the same cycle with count=5 -> count=0, state stays IDLE, and a following start alone is ignored.
- Assert rst during LOAD at word 4 -> din_out=00 and busy=0 immediately; count=0; no done pulse; wr_ready=1.

Source files
------------

// File: rtl/secret_file_loader.sv
// Host-side loader for the secret-file glyph display: buffers 7-bit words, shifts
// them out zero-padded to WORD_COUNT, then drives the play code for play_len cycles.
module secret_file_loader #(
   parameter int WORD_COUNT = 16,
   parameter int PLAY_W     = 16
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               wr_valid,
   output logic                               wr_ready,
   input  logic [6:0]                         wr_data,
   input  logic                               clear,
   input  logic                               start,
   input  logic                               stop,
   input  logic [PLAY_W-1:0]                  play_len,
   output logic [6:0]                         din_out,
   output logic                               busy,
   output logic                               done,
   output logic                               sanitized,
   output logic [$clog2(WORD_COUNT+1)-1:0]    count
);

   localparam int CW = $clog2(WORD_COUNT + 1);
   localparam int IW = $clog2(WORD_COUNT);
   localparam logic [6:0] PLAY_CODE = 7'h7F;

   typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

   state_t            state, state_n;
   logic [IW-1:0]     idx, idx_n;
   logic [PLAY_W-1:0] pctr, play_len_q;
   logic [6:0]        mem [WORD_COUNT];
   logic [6:0]        din_n;
   logic              launch, accept, play_end;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         idx        <= '0;
         pctr       <= '0;
         play_len_q <= '0;
         count      <= '0;
         din_out    <= '0;
         done       <= 1'b0;
         sanitized  <= 1'b0;
      end else begin
         state     <= state_n;
         idx       <= idx_n;
         pctr      <= (state == PLAY) ? pctr + PLAY_W'(1) : '0;
         din_out   <= din_n;
         done      <= (state == PLAY) && (state_n == IDLE);
         sanitized <= accept && (wr_data == PLAY_CODE);
         if (launch)
            play_len_q <= play_len;
         if (state == IDLE) begin
            if (clear)
               count <= '0;
            else if (accept)
               count <= count + CW'(1);
         end
      end
   end

   // The play code is reserved, so it is stored as a blank column instead.
   always_ff @(posedge clk) begin
      if (accept)
         mem[count[IW-1:0]] <= (wr_data == PLAY_CODE) ? 7'h00 : wr_data;
   end

   always_comb begin
      launch   = (state == IDLE) && start && !clear && (count != '0);
      play_end = (play_len_q != '0) && (pctr == play_len_q - PLAY_W'(1));
      state_n  = state;
      case (state)
         IDLE: if (launch) state_n = LOAD;
         LOAD: if (idx == IW'(WORD_COUNT - 1)) state_n = PLAY;
         PLAY: if (stop || play_end) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // din_out is registered, so it is computed from the next state and next index.
   always_comb begin
      busy     = (state != IDLE);
      wr_ready = (state == IDLE) && (count < CW'(WORD_COUNT)) && !launch;
      accept   = wr_valid && wr_ready && !clear;
      idx_n    = (state == LOAD) ? idx + IW'(1) : '0;
      din_n    = 7'h00;
      case (state_n)
         LOAD:    din_n = (CW'(idx_n) < count) ? mem[idx_n] : 7'h00;
         PLAY:    din_n = PLAY_CODE;
         default: din_n = 7'h00;
      endcase
   end

endmodule

// File: tb/tb_secret_file_loader.sv
// Directed bench for secret_file_loader: load/play timing, buffer limits,
// sanitising of the play code, clear priority and asynchronous reset.
module tb_secret_file_loader;

   localparam int WC = 16;
   localparam int PW = 16;

   logic          clk = 1'b0;
   logic          rst, wr_valid, clear, start, stop;
   logic [6:0]    wr_data;
   logic [PW-1:0] play_len;
   logic          wr_ready, busy, done, sanitized;
   logic [6:0]    din_out;
   logic [4:0]    count;

   int errors = 0;
   int checks = 0;
   logic [6:0] model_mem [WC];
   int model_count = 0;

   secret_file_loader #(.WORD_COUNT(WC), .PLAY_W(PW)) dut (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_data(wr_data), .clear(clear), .start(start), .stop(stop),
      .play_len(play_len), .din_out(din_out), .busy(busy), .done(done),
      .sanitized(sanitized), .count(count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [6:0] d);
      wr_valid = 1'b1;
      wr_data  = d;
      tick();
      wr_valid = 1'b0;
      if (model_count < WC) begin
         model_mem[model_count] = (d == 7'h7F) ? 7'h00 : d;
         model_count++;
      end
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      model_count = 0;
   endtask

   task automatic launch(input logic [PW-1:0] pl);
      play_len = pl;
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   task automatic test_reset();
      checks++; if (din_out !== 7'h00) begin errors++; $display("FAIL reset_din: got %h expected 00", din_out); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
      checks++; if (done !== 1'b0 || sanitized !== 1'b0) begin errors++; $display("FAIL reset_pulses: got done=%b san=%b expected 0 0", done, sanitized); end
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b expected 1", wr_ready); end
   endtask

   task automatic test_basic();
      logic [6:0] exp_d;
      int busy_cycles = 0;
      write_word(7'h41);
      write_word(7'h42);
      write_word(7'h03);
      checks++; if (count !== 5'd3) begin errors++; $display("FAIL basic_count: got %0d expected 3", count); end
      launch(16'd20);
      for (int i = 0; i < 37; i++) begin
         if (i == 0) exp_d = 7'h41;
         else if (i == 1) exp_d = 7'h42;
         else if (i == 2) exp_d = 7'h03;
         else if (i < 16) exp_d = 7'h00;
         else if (i < 36) exp_d = 7'h7F;
         else exp_d = 7'h00;
         checks++; if (din_out !== exp_d) begin errors++; $display("FAIL basic_din[%0d]: got %h expected %h", i, din_out, exp_d); end
         checks++; if (done !== (i == 36)) begin errors++; $display("FAIL basic_done[%0d]: got %b expected %b", i, done, (i == 36)); end
         if (busy === 1'b1) busy_cycles++;
         tick();
      end
      checks++; if (busy_cycles != 36) begin errors++; $display("FAIL basic_busy_len: got %0d expected 36", busy_cycles); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b expected 0", done); end
      checks++; if (count !== 5'd3) begin errors++; $display("FAIL basic_count_kept: got %0d expected 3", count); end
   endtask

   task automatic test_full();
      logic [6:0] exp_d;
      do_clear();
      checks++; if (count !== 5'd0) begin errors++; $display("FAIL full_clear: got %0d expected 0", count); end
      for (int i = 0; i < WC; i++) write_word(7'(7'h10 + i));
      checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_wr_ready: got %b expected 0", wr_ready); end
      checks++; if (count !== 5'd16) begin errors++; $display("FAIL full_count: got %0d expected 16", count); end
      wr_valid = 1'b1;
      wr_data  = 7'h55;
      tick();
      wr_valid = 1'b0;
      checks++; if (count !== 5'd16) begin errors++; $display("FAIL full_overflow: got %0d expected 16", count); end
      launch(16'd1);
      for (int i = 0; i < WC + 2; i++) begin
         exp_d = (i < WC) ? model_mem[i] : ((i == WC) ? 7'h7F : 7'h00);
         checks++; if (din_out !== exp_d) begin errors++; $display("FAIL full_din[%0d]: got %h expected %h", i, din_out, exp_d); end
         checks++; if (done !== (i == WC + 1)) begin errors++; $display("FAIL full_done[%0d]: got %b expected %b", i, done, (i == WC + 1)); end
         tick();
      end
   endtask

   task automatic test_sanitize();
      logic [6:0] exp_d;
      do_clear();
      write_word(7'h7F);
      checks++; if (sanitized !== 1'b1) begin errors++; $display("FAIL san_pulse: got %b expected 1", sanitized); end
      checks++; if (count !== 5'd1) begin errors++; $display("FAIL san_count: got %0d expected 1", count); end
      write_word(7'h25);
      checks++; if (sanitized !== 1'b0) begin errors++; $display("FAIL san_once: got %b expected 0", sanitized); end
      launch(16'd2);
      for (int i = 0; i < WC + 3; i++) begin
         if (i == 0) exp_d = 7'h00;
         else if (i == 1) exp_d = 7'h25;
         else if (i < WC) exp_d = 7'h00;
         else if (i < WC + 2) exp_d = 7'h7F;
         else exp_d = 7'h00;
         checks++; if (din_out !== exp_d) begin errors++; $display("FAIL san_din[%0d]: got %h expected %h", i, din_out, exp_d); end
         tick();
      end
   endtask

   task automatic test_play_forever();
      logic [6:0] exp_d;
      launch(16'd0);
      for (int i = 0; i < WC; i++) begin
         exp_d = (i < model_count) ? model_mem[i] : 7'h00;
         checks++; if (din_out !== exp_d) begin errors++; $display("FAIL hold_load[%0d]: got %h expected %h", i, din_out, exp_d); end
         tick();
      end
      for (int i = 0; i < 100; i++) begin
         checks++; if (din_out !== 7'h7F || busy !== 1'b1) begin errors++; $display("FAIL hold_play[%0d]: got din=%h busy=%b expected 7f 1", i, din_out, busy); end
         if (i == 99) stop = 1'b1;
         tick();
      end
      stop = 1'b0;
      checks++; if (din_out !== 7'h00 || done !== 1'b1) begin errors++; $display("FAIL hold_stop: got din=%h done=%b expected 00 1", din_out, done); end
      launch(16'd0);
      stop = 1'b1;
      for (int i = 0; i < WC; i++) begin
         exp_d = (i < model_count) ? model_mem[i] : 7'h00;
         checks++; if (din_out !== exp_d) begin errors++; $display("FAIL replay_load[%0d]: got %h expected %h", i, din_out, exp_d); end
         if (i == WC - 1) stop = 1'b0;
         tick();
      end
      checks++; if (din_out !== 7'h7F) begin errors++; $display("FAIL replay_play: got %h expected 7f", din_out); end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL replay_stop: got done=%b busy=%b expected 1 0", done, busy); end
   endtask

   task automatic test_clear_start();
      do_clear();
      for (int i = 0; i < 5; i++) write_word(7'(7'h30 + i));
      checks++; if (count !== 5'd5) begin errors++; $display("FAIL cs_count5: got %0d expected 5", count); end
      clear = 1'b1;
      start = 1'b1;
      play_len = 16'd3;
      tick();
      clear = 1'b0;
      start = 1'b0;
      model_count = 0;
      checks++; if (count !== 5'd0 || busy !== 1'b0) begin errors++; $display("FAIL cs_clear_wins: got count=%0d busy=%b expected 0 0", count, busy); end
      launch(16'd3);
      checks++; if (busy !== 1'b0 || din_out !== 7'h00) begin errors++; $display("FAIL cs_empty_start: got busy=%b din=%h expected 0 00", busy, din_out); end
   endtask

   task automatic test_reset_load();
      int done_seen = 0;
      for (int i = 0; i < 6; i++) write_word(7'(7'h11 + i));
      launch(16'd5);
      repeat (4) tick();
      checks++; if (din_out !== 7'h15) begin errors++; $display("FAIL rl_word4: got %h expected 15", din_out); end
      #2 rst = 1'b1;
      #1;
      checks++; if (din_out !== 7'h00 || busy !== 1'b0) begin errors++; $display("FAIL rl_async: got din=%h busy=%b expected 00 0", din_out, busy); end
      checks++; if (count !== 5'd0 || wr_ready !== 1'b1) begin errors++; $display("FAIL rl_state: got count=%0d wr_ready=%b expected 0 1", count, wr_ready); end
      #2 rst = 1'b0;
      model_count = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (done !== 1'b0 || busy !== 1'b0) done_seen++;
      end
      checks++; if (done_seen != 0) begin errors++; $display("FAIL rl_no_done: got %0d active cycles expected 0", done_seen); end
   endtask

   initial begin
      rst = 1'b1; wr_valid = 1'b0; wr_data = '0; clear = 1'b0;
      start = 1'b0; stop = 1'b0; play_len = '0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      rst = 1'b0;
      tick();
      test_basic();
      test_full();
      test_sanitize();
      test_play_forever();
      test_clear_start();
      test_reset_load();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
